// File: rtl/riego_scheduler_if.sv
// Request/acknowledge bus between the irrigation scheduler and the valve
// controller: zone request codes G1/G2 out, valve drives R1/R2 and status E back.
interface riego_scheduler_if;
  logic [1:0] G1;
  logic [1:0] G2;
  logic [1:0] R1;
  logic [1:0] R2;
  logic [1:0] E;

  modport master (output G1, output G2, input R1, input R2, input E);
  modport slave  (input G1, input G2, output R1, output R2, output E);
endinterface

// File: rtl/riego_scheduler.sv
// Irrigation request generator: waters the latched valve set one valve at a
// time for a latched number of ticks. Each request must be acknowledged by the
// valve controller. A controller error, or a missing/lost grant, parks the
// block in FAULT until stop. All outputs are registered.
module riego_scheduler #(
  parameter int TICK_DIV = 1000,
  parameter int DUR_W    = 8,
  parameter int ACK_TO   = 8,
  parameter int GAP_CYC  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [3:0]             mask,
  input  logic [DUR_W-1:0]       dur,
  riego_scheduler_if.master      ctl,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [1:0]             cur_valve
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ACK_TO);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_GAP      = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t           state_r,      state_next_s;
  logic [3:0]       mask_r,       mask_next_s;
  logic [DUR_W-1:0] dur_r,        dur_next_s;
  logic [1:0]       cur_valve_r,  cur_next_s;
  logic [1:0]       g1_r,         g1_next_s;
  logic [1:0]       g2_r,         g2_next_s;
  logic             busy_r,       busy_next_s;
  logic             done_r,       done_next_s;
  logic             fault_r,      fault_next_s;
  logic [AW-1:0]    wait_cnt_r,   wait_next_s;
  logic [PW-1:0]    presc_r,      presc_next_s;
  logic [DUR_W-1:0] tick_r,       tick_next_s;
  logic [GW-1:0]    gap_cnt_r,    gap_next_s;

  logic             found_s;
  logic [1:0]       sel_idx_s;
  logic [1:0]       code_s;
  logic [1:0]       r_sel_s;
  logic             err_s;
  logic             grant_s;
  logic [DUR_W-1:0] tick_inc_s;

  // Controller feedback as seen for the zone currently being requested.
  assign r_sel_s    = cur_valve_r[1] ? ctl.R2 : ctl.R1;
  assign err_s      = (ctl.E == 2'b00);
  assign grant_s    = (r_sel_s != 2'b00) && (ctl.E == 2'b01);
  assign tick_inc_s = tick_r + {{(DUR_W-1){1'b0}}, 1'b1};
  assign code_s     = sel_idx_s[0] ? 2'b10 : 2'b01;

  // Lowest pending valve at or above the current index (served bits are cleared).
  always_comb begin
    found_s   = 1'b0;
    sel_idx_s = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_r[i] && (2'(i) >= cur_valve_r)) begin
        found_s   = 1'b1;
        sel_idx_s = 2'(i);
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_next_s = state_r;
    mask_next_s  = mask_r;
    dur_next_s   = dur_r;
    cur_next_s   = cur_valve_r;
    g1_next_s    = g1_r;
    g2_next_s    = g2_r;
    done_next_s  = 1'b0;
    wait_next_s  = wait_cnt_r;
    presc_next_s = presc_r;
    tick_next_s  = tick_r;
    gap_next_s   = gap_cnt_r;

    case (state_r)
      S_IDLE: begin
        g1_next_s  = 2'b00;
        g2_next_s  = 2'b00;
        cur_next_s = 2'd0;
        if (start && !stop) begin
          mask_next_s  = mask;
          dur_next_s   = dur;
          state_next_s = S_SELECT;
        end else begin
          state_next_s = S_IDLE;
        end
      end

      S_SELECT: begin
        if (stop) begin
          state_next_s = S_IDLE;
          cur_next_s   = 2'd0;
        end else if (!found_s || (dur_r == {DUR_W{1'b0}})) begin
          done_next_s  = 1'b1;
          state_next_s = S_IDLE;
          cur_next_s   = 2'd0;
        end else begin
          cur_next_s   = sel_idx_s;
          wait_next_s  = {AW{1'b0}};
          state_next_s = S_WAIT_ACK;
          if (sel_idx_s[1]) begin
            g2_next_s = code_s;
          end else begin
            g1_next_s = code_s;
          end
        end
      end

      S_WAIT_ACK: begin
        if (stop) begin
          g1_next_s    = 2'b00;
          g2_next_s    = 2'b00;
          cur_next_s   = 2'd0;
          state_next_s = S_IDLE;
        end else if (err_s) begin
          g1_next_s    = 2'b00;
          g2_next_s    = 2'b00;
          state_next_s = S_FAULT;
        end else if (grant_s) begin
          presc_next_s = {PW{1'b0}};
          tick_next_s  = {DUR_W{1'b0}};
          state_next_s = S_RUN;
        end else if (wait_cnt_r == AW'(ACK_TO - 1)) begin
          g1_next_s    = 2'b00;
          g2_next_s    = 2'b00;
          state_next_s = S_FAULT;
        end else begin
          wait_next_s  = wait_cnt_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end

      S_RUN: begin
        if (stop) begin
          g1_next_s    = 2'b00;
          g2_next_s    = 2'b00;
          cur_next_s   = 2'd0;
          state_next_s = S_IDLE;
        end else if (err_s || (r_sel_s == 2'b00)) begin
          g1_next_s    = 2'b00;
          g2_next_s    = 2'b00;
          state_next_s = S_FAULT;
        end else if (presc_r == PW'(TICK_DIV - 1)) begin
          presc_next_s = {PW{1'b0}};
          tick_next_s  = tick_inc_s;
          if (tick_inc_s == dur_r) begin
            g1_next_s    = 2'b00;
            g2_next_s    = 2'b00;
            gap_next_s   = {GW{1'b0}};
            state_next_s = S_GAP;
          end else begin
            state_next_s = S_RUN;
          end
        end else begin
          presc_next_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
      end

      S_GAP: begin
        g1_next_s = 2'b00;
        g2_next_s = 2'b00;
        if (stop) begin
          cur_next_s   = 2'd0;
          state_next_s = S_IDLE;
        end else if (gap_cnt_r == GW'(GAP_CYC - 1)) begin
          // Retire the valve just served; SELECT then moves past it.
          mask_next_s[cur_valve_r] = 1'b0;
          state_next_s             = S_SELECT;
        end else begin
          gap_next_s = gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
        end
      end

      S_FAULT: begin
        g1_next_s = 2'b00;
        g2_next_s = 2'b00;
        if (stop) begin
          cur_next_s   = 2'd0;
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_FAULT;
        end
      end

      default: begin
        g1_next_s    = 2'b00;
        g2_next_s    = 2'b00;
        cur_next_s   = 2'd0;
        state_next_s = S_IDLE;
      end
    endcase

    busy_next_s  = (state_next_s != S_IDLE);
    fault_next_s = (state_next_s == S_FAULT);
  end

  // State, latches, counters and registered outputs; reset drops any request at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      mask_r      <= 4'b0000;
      dur_r       <= {DUR_W{1'b0}};
      cur_valve_r <= 2'd0;
      g1_r        <= 2'b00;
      g2_r        <= 2'b00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      wait_cnt_r  <= {AW{1'b0}};
      presc_r     <= {PW{1'b0}};
      tick_r      <= {DUR_W{1'b0}};
      gap_cnt_r   <= {GW{1'b0}};
    end else begin
      state_r     <= state_next_s;
      mask_r      <= mask_next_s;
      dur_r       <= dur_next_s;
      cur_valve_r <= cur_next_s;
      g1_r        <= g1_next_s;
      g2_r        <= g2_next_s;
      busy_r      <= busy_next_s;
      done_r      <= done_next_s;
      fault_r     <= fault_next_s;
      wait_cnt_r  <= wait_next_s;
      presc_r     <= presc_next_s;
      tick_r      <= tick_next_s;
      gap_cnt_r   <= gap_next_s;
    end
  end

  assign ctl.G1    = g1_r;
  assign ctl.G2    = g2_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign fault     = fault_r;
  assign cur_valve = cur_valve_r;

endmodule

// File: tb/tb_riego_scheduler.sv
// Directed bench for riego_scheduler with a small valve-controller model.
module tb_riego_scheduler;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 8;
  localparam int ACK_TO   = 8;
  localparam int GAP_CYC  = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic [3:0]       mask;
  logic [DUR_W-1:0] dur;
  logic             busy;
  logic             done;
  logic             fault;
  logic [1:0]       cur_valve;

  // Controller model: 0 = never grants, 1 = grants in the same cycle, 2 = grants one cycle later
  logic [1:0] mode;
  logic [1:0] e_drv;
  logic [1:0] g1_d;
  logic [1:0] g2_d;

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;
  int done_cnt = 0;
  int n;
  int d0;

  riego_scheduler_if ctl_if ();

  riego_scheduler #(
    .TICK_DIV (TICK_DIV),
    .DUR_W    (DUR_W),
    .ACK_TO   (ACK_TO),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mask      (mask),
    .dur       (dur),
    .ctl       (ctl_if),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .cur_valve (cur_valve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delayed copy of the requests for the late-grant controller mode.
  always @(posedge clk) begin
    g1_d <= ctl_if.G1;
    g2_d <= ctl_if.G2;
  end

  assign ctl_if.R1 = (mode == 2'd1) ? ctl_if.G1 : (mode == 2'd2) ? g1_d : 2'b00;
  assign ctl_if.R2 = (mode == 2'd1) ? ctl_if.G2 : (mode == 2'd2) ? g2_d : 2'b00;
  assign ctl_if.E  = e_drv;

  // Watch for both zones requested at once and count done pulses.
  always @(negedge clk) begin
    if ((ctl_if.G1 != 2'b00) && (ctl_if.G2 != 2'b00)) both_cnt <= both_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Cycles for which some request stays non-zero (bounded).
  task automatic count_req(output int cnt);
    cnt = 0;
    while (((ctl_if.G1 != 2'b00) || (ctl_if.G2 != 2'b00)) && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  // Cycles with no request and no done, until one of them appears (bounded).
  task automatic count_idle(output int cnt);
    cnt = 0;
    while ((ctl_if.G1 == 2'b00) && (ctl_if.G2 == 2'b00) && !done && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mask  = 4'b0000;
    dur   = 8'd0;
    mode  = 2'd0;
    e_drv = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_g1",   32'(ctl_if.G1), 32'd0);
    check_val("rst_g2",   32'(ctl_if.G2), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_cur",  32'(cur_valve), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single valve, grant one cycle late, 3 ticks of 4 cycles
    mode = 2'd2; mask = 4'b0001; dur = 8'd3;
    pulse_start();
    check_val("t1_busy", 32'(busy), 32'd1);
    tick();
    check_val("t1_g1_lat", 32'(ctl_if.G1), 32'd1);
    check_val("t1_cur", 32'(cur_valve), 32'd0);
    count_req(n);
    check_val("t1_req_len", 32'(n), 32'(2 + 3 * TICK_DIV));
    count_idle(n);
    check_val("t1_gap_len", 32'(n), 32'(GAP_CYC + 1));
    check_val("t1_done", 32'(done), 32'd1);
    check_val("t1_busy_end", 32'(busy), 32'd0);
    tick();
    check_val("t1_done_pulse", 32'(done), 32'd0);

    // Two valves across both zones, immediate grants
    mode = 2'd1; mask = 4'b1010; dur = 8'd2;
    d0 = done_cnt;
    pulse_start();
    tick();
    check_val("t2_g1", 32'(ctl_if.G1), 32'd2);
    check_val("t2_cur1", 32'(cur_valve), 32'd1);
    count_req(n);
    check_val("t2_req1_len", 32'(n), 32'(1 + 2 * TICK_DIV));
    count_idle(n);
    check_val("t2_gap_len", 32'(n), 32'(GAP_CYC + 1));
    check_val("t2_g2", 32'(ctl_if.G2), 32'd2);
    check_val("t2_g1_off", 32'(ctl_if.G1), 32'd0);
    check_val("t2_cur3", 32'(cur_valve), 32'd3);
    count_req(n);
    check_val("t2_req2_len", 32'(n), 32'(1 + 2 * TICK_DIV));
    count_idle(n);
    check_val("t2_done", 32'(done), 32'd1);
    tick();
    check_val("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_val("t2_both", 32'(both_cnt), 32'd0);

    // No grant ever: timeout fault, start ignored, stop clears
    mode = 2'd0; mask = 4'b0100; dur = 8'd5;
    pulse_start();
    tick();
    check_val("t3_g2", 32'(ctl_if.G2), 32'd1);
    check_val("t3_cur", 32'(cur_valve), 32'd2);
    count_req(n);
    check_val("t3_wait_len", 32'(n), 32'(ACK_TO));
    check_val("t3_fault", 32'(fault), 32'd1);
    check_val("t3_g2_off", 32'(ctl_if.G2), 32'd0);
    pulse_start();
    check_val("t3_fault_hold", 32'(fault), 32'd1);
    check_val("t3_busy_hold", 32'(busy), 32'd1);
    pulse_stop();
    check_val("t3_fault_clr", 32'(fault), 32'd0);
    check_val("t3_busy_clr", 32'(busy), 32'd0);

    // Controller error during RUN
    mode = 2'd1; mask = 4'b0001; dur = 8'd3;
    pulse_start();
    tick();
    tick();
    tick();
    check_val("t4_g1_run", 32'(ctl_if.G1), 32'd1);
    e_drv = 2'b00;
    tick();
    check_val("t4_g1_off", 32'(ctl_if.G1), 32'd0);
    check_val("t4_fault", 32'(fault), 32'd1);
    e_drv = 2'b01;
    pulse_start();
    check_val("t4_fault_hold", 32'(fault), 32'd1);
    check_val("t4_g1_hold", 32'(ctl_if.G1), 32'd0);
    pulse_stop();
    check_val("t4_busy_clr", 32'(busy), 32'd0);

    // Empty mask and zero duration: done two cycles after start, no request
    mask = 4'b0000; dur = 8'd5;
    pulse_start();
    check_val("t5a_done_early", 32'(done), 32'd0);
    tick();
    check_val("t5a_done", 32'(done), 32'd1);
    check_val("t5a_req", 32'(ctl_if.G1 | ctl_if.G2), 32'd0);
    tick();
    mask = 4'b1111; dur = 8'd0;
    pulse_start();
    check_val("t5b_done_early", 32'(done), 32'd0);
    tick();
    check_val("t5b_done", 32'(done), 32'd1);
    check_val("t5b_req", 32'(ctl_if.G1 | ctl_if.G2), 32'd0);
    check_val("t5b_busy", 32'(busy), 32'd0);
    tick();

    // Asynchronous reset in the middle of RUN on valve 3
    mode = 2'd1; mask = 4'b1000; dur = 8'd3;
    pulse_start();
    tick();
    tick();
    check_val("t6_g2_run", 32'(ctl_if.G2), 32'd2);
    check_val("t6_cur_run", 32'(cur_valve), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_val("t6_g2_async", 32'(ctl_if.G2), 32'd0);
    check_val("t6_busy_async", 32'(busy), 32'd0);
    check_val("t6_cur_async", 32'(cur_valve), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // start and stop together in IDLE
    mask = 4'b0001; dur = 8'd3;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_val("t7_busy", 32'(busy), 32'd0);
    tick();
    check_val("t7_busy2", 32'(busy), 32'd0);
    check_val("t7_req", 32'(ctl_if.G1 | ctl_if.G2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
